// File: rtl/psum_acc_scheduler.sv
// psum_acc_scheduler
// Layer-level sequencer between the 16x16 PE array and the psum accumulator.
// Each PE psum hand-off becomes one accumulator pass. Passes are counted per
// output tile, with first-pass and last-pass flags. The PE psum RF address and
// the psum BRAM tile base advance between passes and between tiles.
// Every output comes straight from a register.

module psum_acc_scheduler #(
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int BRAM_ADDR_BITWIDTH    = 10,
    parameter int ROWS_PER_TILE         = 8,
    parameter int CNT_BITWIDTH          = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [CNT_BITWIDTH-1:0]          cfg_acc_num,
    input  logic [CNT_BITWIDTH-1:0]          cfg_tile_num,
    input  logic [BRAM_ADDR_BITWIDTH-1:0]    cfg_base_addr,
    input  logic                             pe_psum_finish,
    input  logic                             su_add_finish,
    output logic                             pe_psum_ack,
    output logic                             acc_start,
    output logic                             acc_first,
    output logic                             conv_finish,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr,
    output logic [BRAM_ADDR_BITWIDTH-1:0]    acc_base_addr,
    output logic                             tile_done,
    output logic                             done,
    output logic                             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PSUM,
        S_ISSUE,
        S_WAIT_ADD,
        S_NEXT
    } state_t;

    localparam logic [CNT_BITWIDTH-1:0]          CNT_ONE  = CNT_BITWIDTH'(1);
    localparam logic [PSUM_RF_ADDR_BITWIDTH-1:0] RF_ONE   = PSUM_RF_ADDR_BITWIDTH'(1);
    localparam logic [BRAM_ADDR_BITWIDTH-1:0]    TILE_INC = BRAM_ADDR_BITWIDTH'(ROWS_PER_TILE);

    // Registered state
    state_t                             r_state;
    logic [CNT_BITWIDTH-1:0]            r_acc_num;
    logic [CNT_BITWIDTH-1:0]            r_tile_num;
    logic [CNT_BITWIDTH-1:0]            r_acc_cnt;
    logic [CNT_BITWIDTH-1:0]            r_tile_cnt;
    logic                               r_armed;
    logic                               r_ack;
    logic                               r_acc_start;
    logic                               r_acc_first;
    logic                               r_conv_finish;
    logic [PSUM_RF_ADDR_BITWIDTH-1:0]   r_rf_addr;
    logic [BRAM_ADDR_BITWIDTH-1:0]      r_base_addr;
    logic                               r_tile_done;
    logic                               r_done;
    logic                               r_busy;

    // Next-state values
    state_t                             w_state;
    logic [CNT_BITWIDTH-1:0]            w_acc_num;
    logic [CNT_BITWIDTH-1:0]            w_tile_num;
    logic [CNT_BITWIDTH-1:0]            w_acc_cnt;
    logic [CNT_BITWIDTH-1:0]            w_tile_cnt;
    logic                               w_ack;
    logic                               w_acc_start;
    logic                               w_acc_first;
    logic                               w_conv_finish;
    logic [PSUM_RF_ADDR_BITWIDTH-1:0]   w_rf_addr;
    logic [BRAM_ADDR_BITWIDTH-1:0]      w_base_addr;
    logic                               w_tile_done;
    logic                               w_done;
    logic                               w_busy;

    logic                               w_last_pass;
    logic                               w_last_tile;

    // r_acc_num is never 0 once latched; r_tile_num is never 0 while busy.
    assign w_last_pass = (r_acc_cnt  == (r_acc_num  - CNT_ONE));
    assign w_last_tile = (r_tile_cnt == (r_tile_num - CNT_ONE));

    // Next-state and next-output logic for the pass sequencer
    always_comb begin
        w_state       = r_state;
        w_acc_num     = r_acc_num;
        w_tile_num    = r_tile_num;
        w_acc_cnt     = r_acc_cnt;
        w_tile_cnt    = r_tile_cnt;
        w_acc_first   = r_acc_first;
        w_conv_finish = r_conv_finish;
        w_rf_addr     = r_rf_addr;
        w_base_addr   = r_base_addr;
        w_busy        = r_busy;
        w_ack         = 1'b0;
        w_acc_start   = 1'b0;
        w_tile_done   = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_num   = (cfg_acc_num == '0) ? CNT_ONE : cfg_acc_num;
                    w_tile_num  = cfg_tile_num;
                    w_acc_cnt   = '0;
                    w_tile_cnt  = '0;
                    w_rf_addr   = '0;
                    w_base_addr = cfg_base_addr;
                    if (cfg_tile_num == '0) begin
                        // Empty layer: report completion without touching the PE array
                        w_done = 1'b1;
                        w_busy = 1'b0;
                    end else begin
                        w_busy  = 1'b1;
                        w_state = S_WAIT_PSUM;
                    end
                end
            end

            S_WAIT_PSUM: begin
                // A psum level still held from the previous ack is not accepted until re-armed
                if (pe_psum_finish && r_armed) begin
                    w_acc_start   = 1'b1;
                    w_acc_first   = (r_acc_cnt == '0);
                    w_conv_finish = w_last_pass;
                    w_state       = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_state = S_WAIT_ADD;
            end

            S_WAIT_ADD: begin
                if (su_add_finish) begin
                    w_ack         = 1'b1;
                    w_acc_first   = 1'b0;
                    w_conv_finish = 1'b0;
                    w_rf_addr     = r_rf_addr + RF_ONE;
                    w_state       = S_NEXT;
                    if (!w_last_pass) begin
                        w_acc_cnt = r_acc_cnt + CNT_ONE;
                    end else begin
                        w_tile_done = 1'b1;
                        w_acc_cnt   = '0;
                        w_tile_cnt  = r_tile_cnt + CNT_ONE;
                        w_base_addr = r_base_addr + TILE_INC;
                        if (w_last_tile) begin
                            w_done = 1'b1;
                            w_busy = 1'b0;
                        end
                    end
                end
            end

            S_NEXT: begin
                // busy already dropped on entry when this was the layer's final pass
                w_state = r_busy ? S_WAIT_PSUM : S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Counters, latched config and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_num     <= '0;
            r_tile_num    <= '0;
            r_acc_cnt     <= '0;
            r_tile_cnt    <= '0;
            r_ack         <= 1'b0;
            r_acc_start   <= 1'b0;
            r_acc_first   <= 1'b0;
            r_conv_finish <= 1'b0;
            r_rf_addr     <= '0;
            r_base_addr   <= '0;
            r_tile_done   <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_acc_num     <= w_acc_num;
            r_tile_num    <= w_tile_num;
            r_acc_cnt     <= w_acc_cnt;
            r_tile_cnt    <= w_tile_cnt;
            r_ack         <= w_ack;
            r_acc_start   <= w_acc_start;
            r_acc_first   <= w_acc_first;
            r_conv_finish <= w_conv_finish;
            r_rf_addr     <= w_rf_addr;
            r_base_addr   <= w_base_addr;
            r_tile_done   <= w_tile_done;
            r_done        <= w_done;
            r_busy        <= w_busy;
        end
    end

    // Re-arm tracking: disarmed by our ack, re-armed once the PE drops its psum level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b1;
        end else if (r_ack) begin
            r_armed <= 1'b0;
        end else if (!pe_psum_finish) begin
            r_armed <= 1'b1;
        end
    end

    assign pe_psum_ack   = r_ack;
    assign acc_start     = r_acc_start;
    assign acc_first     = r_acc_first;
    assign conv_finish   = r_conv_finish;
    assign psum_rf_addr  = r_rf_addr;
    assign acc_base_addr = r_base_addr;
    assign tile_done     = r_tile_done;
    assign done          = r_done;
    assign busy          = r_busy;

endmodule

// File: tb/tb_psum_acc_scheduler.sv
// Directed bench for psum_acc_scheduler: a small PE/accumulator responder
// drives the handshakes, and a negedge monitor logs every pass start.

module tb_psum_acc_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_acc_num = '0;
    logic [7:0] cfg_tile_num = '0;
    logic [9:0] cfg_base_addr = '0;
    logic       pe_psum_finish = 1'b0;
    logic       su_add_finish = 1'b0;
    logic       pe_psum_ack, acc_start, acc_first, conv_finish;
    logic [1:0] psum_rf_addr;
    logic [9:0] acc_base_addr;
    logic       tile_done, done, busy;

    int n_chk = 0;
    int n_pass = 0;

    psum_acc_scheduler #(
        .PSUM_RF_ADDR_BITWIDTH(2),
        .BRAM_ADDR_BITWIDTH(10),
        .ROWS_PER_TILE(8),
        .CNT_BITWIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_acc_num(cfg_acc_num), .cfg_tile_num(cfg_tile_num), .cfg_base_addr(cfg_base_addr),
        .pe_psum_finish(pe_psum_finish), .su_add_finish(su_add_finish),
        .pe_psum_ack(pe_psum_ack), .acc_start(acc_start), .acc_first(acc_first),
        .conv_finish(conv_finish), .psum_rf_addr(psum_rf_addr), .acc_base_addr(acc_base_addr),
        .tile_done(tile_done), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pass log, sampled on the falling edge
    int         n_start = 0;
    int         n_tdone = 0;
    int         n_done  = 0;
    logic       lg_first [256];
    logic       lg_conv  [256];
    logic [1:0] lg_rf    [256];
    logic [9:0] lg_base  [256];

    always @(negedge clk) begin
        if (acc_start && n_start < 256) begin
            lg_first[n_start] <= acc_first;
            lg_conv[n_start]  <= conv_finish;
            lg_rf[n_start]    <= psum_rf_addr;
            lg_base[n_start]  <= acc_base_addr;
            n_start           <= n_start + 1;
        end
        if (tile_done) n_tdone <= n_tdone + 1;
        if (done)      n_done  <= n_done + 1;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (acc_start) begin ok = 1'b1; break; end
        end
    endtask

    // PE answers each ack by dropping psum for two cycles; accumulator finishes 2 cycles after acc_start
    task automatic auto_run(input int budget, output bit got);
        int low = 1;
        int add = -1;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (done) begin got = 1'b1; break; end
            if (acc_start) add = 2;
            su_add_finish = (add == 0);
            if (add >= 0) add--;
            if (pe_psum_ack) low = 2;
            pe_psum_finish = (low == 0);
            if (low > 0) low--;
        end
        pe_psum_finish = 1'b0;
        su_add_finish  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_layer1(input string tag);
        int s0, t0, d0;
        bit got;
        logic [9:0] exp_base;
        s0 = n_start; t0 = n_tdone; d0 = n_done;
        cfg_acc_num = 8'd3; cfg_tile_num = 8'd2; cfg_base_addr = 10'h010;
        pulse_start();
        auto_run(300, got);
        n_chk++; if (got !== 1'b1) $display("FAIL %s done_seen got=%0b exp=1", tag, got); else n_pass++;
        n_chk++; if (n_start - s0 !== 6) $display("FAIL %s pass_count got=%0d exp=6", tag, n_start - s0); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            exp_base = (i < 3) ? 10'h010 : 10'h018;
            n_chk++; if (lg_first[s0+i] !== (i % 3 == 0)) $display("FAIL %s acc_first[%0d] got=%0b exp=%0b", tag, i, lg_first[s0+i], (i % 3 == 0)); else n_pass++;
            n_chk++; if (lg_conv[s0+i] !== (i % 3 == 2)) $display("FAIL %s conv_finish[%0d] got=%0b exp=%0b", tag, i, lg_conv[s0+i], (i % 3 == 2)); else n_pass++;
            n_chk++; if (lg_rf[s0+i] !== 2'(i % 4)) $display("FAIL %s rf_addr[%0d] got=%0d exp=%0d", tag, i, lg_rf[s0+i], i % 4); else n_pass++;
            n_chk++; if (lg_base[s0+i] !== exp_base) $display("FAIL %s base[%0d] got=%h exp=%h", tag, i, lg_base[s0+i], exp_base); else n_pass++;
        end
        n_chk++; if (n_tdone - t0 !== 2) $display("FAIL %s tile_done_count got=%0d exp=2", tag, n_tdone - t0); else n_pass++;
        n_chk++; if (n_done - d0 !== 1) $display("FAIL %s done_count got=%0d exp=1", tag, n_done - d0); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL %s busy_after got=%0b exp=0", tag, busy); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset busy got=%0b exp=0", busy); else n_pass++;
        n_chk++; if ({pe_psum_ack, acc_start, acc_first, conv_finish, tile_done, done} !== 6'b0)
            $display("FAIL reset pulses got=%b exp=000000", {pe_psum_ack, acc_start, acc_first, conv_finish, tile_done, done}); else n_pass++;
        n_chk++; if (psum_rf_addr !== 2'd0) $display("FAIL reset rf_addr got=%0d exp=0", psum_rf_addr); else n_pass++;
        n_chk++; if (acc_base_addr !== 10'h000) $display("FAIL reset base got=%h exp=000", acc_base_addr); else n_pass++;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset idle_busy got=%0b exp=0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        chk_layer1("basic");
    endtask

    task automatic test_held_psum();
        int s0, t0;
        bit ok;
        s0 = n_start; t0 = n_tdone;
        cfg_acc_num = 8'd2; cfg_tile_num = 8'd1; cfg_base_addr = 10'h100;
        pulse_start();
        pe_psum_finish = 1'b1;
        wait_start(50, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL held first_start got=%0b exp=1", ok); else n_pass++;
        // A start with different cfg while busy must be ignored
        start = 1'b1; cfg_acc_num = 8'd1; cfg_tile_num = 8'd5;
        @(posedge clk); #1 start = 1'b0; su_add_finish = 1'b1;
        @(posedge clk); #1 su_add_finish = 1'b0;
        n_chk++; if (pe_psum_ack !== 1'b1) $display("FAIL held ack got=%0b exp=1", pe_psum_ack); else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_chk++; if (n_start - s0 !== 1) $display("FAIL held no_restart got=%0d exp=1", n_start - s0); else n_pass++;
        pe_psum_finish = 1'b0;
        @(posedge clk); #1 pe_psum_finish = 1'b1;
        wait_start(50, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL held second_start got=%0b exp=1", ok); else n_pass++;
        n_chk++; if ({acc_first, conv_finish} !== 2'b01) $display("FAIL held pass2_flags got=%b exp=01", {acc_first, conv_finish}); else n_pass++;
        pe_psum_finish = 1'b0;
        @(posedge clk); #1 su_add_finish = 1'b1;
        @(posedge clk); #1 su_add_finish = 1'b0;
        n_chk++; if ({tile_done, done} !== 2'b11) $display("FAIL held finish got=%b exp=11", {tile_done, done}); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (n_tdone - t0 !== 1) $display("FAIL held tile_count got=%0d exp=1", n_tdone - t0); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL held busy_after got=%0b exp=0", busy); else n_pass++;
    endtask

    task automatic test_stray_add();
        int s0, t0, d0;
        bit ok, got;
        s0 = n_start; t0 = n_tdone; d0 = n_done;
        cfg_acc_num = 8'd2; cfg_tile_num = 8'd1; cfg_base_addr = 10'h020;
        pulse_start();
        @(posedge clk); #1 su_add_finish = 1'b1;
        @(posedge clk); #1 su_add_finish = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (n_start - s0 !== 0) $display("FAIL stray no_start got=%0d exp=0", n_start - s0); else n_pass++;
        n_chk++; if (psum_rf_addr !== 2'd0) $display("FAIL stray rf_addr got=%0d exp=0", psum_rf_addr); else n_pass++;
        n_chk++; if ({pe_psum_ack, tile_done, busy} !== 3'b001) $display("FAIL stray state got=%b exp=001", {pe_psum_ack, tile_done, busy}); else n_pass++;
        pe_psum_finish = 1'b1;
        wait_start(50, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL stray start_seen got=%0b exp=1", ok); else n_pass++;
        n_chk++; if ({acc_first, conv_finish} !== 2'b10) $display("FAIL stray pass1_flags got=%b exp=10", {acc_first, conv_finish}); else n_pass++;
        pe_psum_finish = 1'b0;
        @(posedge clk); #1 su_add_finish = 1'b1;
        @(posedge clk); #1 su_add_finish = 1'b0;
        n_chk++; if ({pe_psum_ack, psum_rf_addr} !== 3'b101) $display("FAIL stray ack_rf got=%b exp=101", {pe_psum_ack, psum_rf_addr}); else n_pass++;
        auto_run(200, got);
        n_chk++; if (got !== 1'b1) $display("FAIL stray done_seen got=%0b exp=1", got); else n_pass++;
        n_chk++; if (n_start - s0 !== 2) $display("FAIL stray pass_count got=%0d exp=2", n_start - s0); else n_pass++;
        n_chk++; if ({lg_first[s0+1], lg_conv[s0+1]} !== 2'b01) $display("FAIL stray pass2_flags got=%b exp=01", {lg_first[s0+1], lg_conv[s0+1]}); else n_pass++;
        n_chk++; if (n_tdone - t0 !== 1 || n_done - d0 !== 1) $display("FAIL stray tile_done_done got=%0d,%0d exp=1,1", n_tdone - t0, n_done - d0); else n_pass++;
    endtask

    task automatic test_edge_cfg();
        int s0;
        bit got;
        s0 = n_start;
        cfg_acc_num = 8'd4; cfg_tile_num = 8'd0; cfg_base_addr = 10'h055;
        pulse_start();
        n_chk++; if ({done, busy} !== 2'b10) $display("FAIL empty done_pulse got=%b exp=10", {done, busy}); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (done !== 1'b0) $display("FAIL empty done_one_cycle got=%0b exp=0", done); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (n_start - s0 !== 0) $display("FAIL empty no_pass got=%0d exp=0", n_start - s0); else n_pass++;

        s0 = n_start;
        cfg_acc_num = 8'd0; cfg_tile_num = 8'd1; cfg_base_addr = 10'h040;
        pulse_start();
        auto_run(200, got);
        n_chk++; if (got !== 1'b1) $display("FAIL acc0 done_seen got=%0b exp=1", got); else n_pass++;
        n_chk++; if (n_start - s0 !== 1) $display("FAIL acc0 pass_count got=%0d exp=1", n_start - s0); else n_pass++;
        n_chk++; if ({lg_first[s0], lg_conv[s0]} !== 2'b11) $display("FAIL acc0 flags got=%b exp=11", {lg_first[s0], lg_conv[s0]}); else n_pass++;
        n_chk++; if (lg_base[s0] !== 10'h040) $display("FAIL acc0 base got=%h exp=040", lg_base[s0]); else n_pass++;
    endtask

    task automatic test_base_wrap();
        int s0;
        bit got;
        logic [9:0] exp_b [3];
        exp_b[0] = 10'h3FC; exp_b[1] = 10'h004; exp_b[2] = 10'h00C;
        s0 = n_start;
        cfg_acc_num = 8'd1; cfg_tile_num = 8'd3; cfg_base_addr = 10'h3FC;
        pulse_start();
        auto_run(300, got);
        n_chk++; if (got !== 1'b1) $display("FAIL wrap done_seen got=%0b exp=1", got); else n_pass++;
        n_chk++; if (n_start - s0 !== 3) $display("FAIL wrap pass_count got=%0d exp=3", n_start - s0); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (lg_base[s0+i] !== exp_b[i]) $display("FAIL wrap base[%0d] got=%h exp=%h", i, lg_base[s0+i], exp_b[i]); else n_pass++;
            n_chk++; if ({lg_first[s0+i], lg_conv[s0+i]} !== 2'b11) $display("FAIL wrap flags[%0d] got=%b exp=11", i, {lg_first[s0+i], lg_conv[s0+i]}); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        cfg_acc_num = 8'd3; cfg_tile_num = 8'd2; cfg_base_addr = 10'h010;
        pulse_start();
        pe_psum_finish = 1'b1;
        wait_start(50, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL midrst start_seen got=%0b exp=1", ok); else n_pass++;
        pe_psum_finish = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({acc_first, busy, acc_base_addr} !== {2'b11, 10'h010}) $display("FAIL midrst pre got=%b exp=%b", {acc_first, busy, acc_base_addr}, {2'b11, 10'h010}); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_chk++; if ({pe_psum_ack, acc_start, acc_first, conv_finish, tile_done, done, busy} !== 7'b0)
            $display("FAIL midrst flags got=%b exp=0000000", {pe_psum_ack, acc_start, acc_first, conv_finish, tile_done, done, busy}); else n_pass++;
        n_chk++; if ({psum_rf_addr, acc_base_addr} !== 12'h000) $display("FAIL midrst addrs got=%h exp=000", {psum_rf_addr, acc_base_addr}); else n_pass++;
        @(negedge clk) reset = 1'b1;
        chk_layer1("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_psum();
        test_stray_add();
        test_edge_cfg();
        test_base_wrap();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
